// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - shared washer control panel constants and state encoding
//
// Purpose : holds the 3-bit panel state encoding and the default debounce and
//           start-acknowledge timeout values. wm_control_panel and
//           wm_debounce both import it.
// Ports   : none (package)
package wm_pkg;

  localparam int DEFAULT_DEBOUNCE_CNT = 4;
  localparam int DEFAULT_ACK_TIMEOUT  = 8;

  typedef enum logic [2:0] {
    PANEL_IDLE     = 3'd0,
    PANEL_LAUNCH   = 3'd1,
    PANEL_WAIT_ACK = 3'd2,
    PANEL_RUN      = 3'd3,
    PANEL_PAUSED   = 3'd4,
    PANEL_COMPLETE = 3'd5
  } panel_state_t;

endpackage

// File: rtl/wm_debounce.sv
// rtl/wm_debounce.sv - button synchronizer, debouncer and press pulse
//
// Purpose : passes a raw asynchronous push-button through a 2-flop
//           synchronizer and a stability counter. It emits a 1-cycle press
//           pulse on the debounced rising edge.
// Ports   : clk, rst_n (sync active-low) ; btn raw button ;
//           press 1-cycle pulse, high in the cycle the debounced level rises
module wm_debounce
  import wm_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEFAULT_DEBOUNCE_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;
  logic          last_sample;

  // The current differing sample is the DEBOUNCE_CNT-th one in a row.
  assign last_sample = (cnt == CW'(DEBOUNCE_CNT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (last_sample) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wm_control_panel.sv
// rtl/wm_control_panel.sv - washing machine front panel sequencer
//
// Purpose : debounces start/pause buttons and sequences a wash cycle. It
//           latches the program options, issues a start pulse and waits for
//           the washer to drop done. It then tracks run/pause/complete and
//           flags a washer that never acknowledges the start.
// Ports   : clk, rst_n (sync active-low)
//           start_btn, pause_btn raw buttons ; double_sel, dry_sel selectors
//           done washer done flag
//           start 1-cycle pulse ; double_wash, dry_wash latched options
//           time_pause, running, cycle_complete status ; ack_error sticky
module wm_control_panel
  import wm_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEFAULT_DEBOUNCE_CNT,
  parameter int ACK_TIMEOUT  = DEFAULT_ACK_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_btn,
  input  logic pause_btn,
  input  logic double_sel,
  input  logic dry_sel,
  input  logic done,
  output logic start,
  output logic double_wash,
  output logic dry_wash,
  output logic time_pause,
  output logic running,
  output logic cycle_complete,
  output logic ack_error
);

  localparam int AW = $clog2(ACK_TIMEOUT + 1);

  panel_state_t  state, state_nxt;
  logic          start_press;
  logic          pause_press;
  logic          accept_start;
  logic          ack_hit;
  logic [AW-1:0] ack_cnt;

  wm_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_start_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (start_btn),
    .press (start_press)
  );

  wm_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_pause_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (pause_btn),
    .press (pause_press)
  );

  assign accept_start = start_press &&
                        ((state == PANEL_IDLE) || (state == PANEL_COMPLETE));
  // done is still high on the sample that would make the count hit the limit.
  assign ack_hit = done && (ack_cnt == AW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= PANEL_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PANEL_IDLE:     if (start_press) state_nxt = PANEL_LAUNCH;
      PANEL_LAUNCH:   state_nxt = PANEL_WAIT_ACK;
      PANEL_WAIT_ACK: begin
        if (!done)        state_nxt = PANEL_RUN;
        else if (ack_hit) state_nxt = PANEL_IDLE;
      end
      PANEL_RUN: begin
        // A finished washer wins over a pause request on the same cycle.
        if (done)             state_nxt = PANEL_COMPLETE;
        else if (pause_press) state_nxt = PANEL_PAUSED;
      end
      PANEL_PAUSED: begin
        if (done)             state_nxt = PANEL_COMPLETE;
        else if (pause_press) state_nxt = PANEL_RUN;
      end
      PANEL_COMPLETE: if (start_press) state_nxt = PANEL_LAUNCH;
      default:        state_nxt = PANEL_IDLE;
    endcase
  end

  always_comb begin
    start          = (state == PANEL_LAUNCH);
    time_pause     = (state == PANEL_PAUSED);
    cycle_complete = (state == PANEL_COMPLETE);
    running        = (state == PANEL_LAUNCH) || (state == PANEL_WAIT_ACK) ||
                     (state == PANEL_RUN)    || (state == PANEL_PAUSED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      double_wash <= 1'b0;
      dry_wash    <= 1'b0;
      ack_error   <= 1'b0;
      ack_cnt     <= '0;
    end else begin
      if (accept_start) begin
        // Dry wash overrides double wash when both selectors are set.
        dry_wash    <= dry_sel;
        double_wash <= double_sel && !dry_sel;
        ack_error   <= 1'b0;
      end else if ((state == PANEL_WAIT_ACK) && ack_hit) begin
        ack_error <= 1'b1;
      end
      if ((state == PANEL_WAIT_ACK) && done && !ack_hit) ack_cnt <= ack_cnt + 1'b1;
      else                                              ack_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_wm_control_panel.sv
// tb/tb_wm_control_panel.sv - directed self-checking bench for wm_control_panel
module tb_wm_control_panel;

  logic clk = 1'b0;
  logic rst_n, start_btn, pause_btn, double_sel, dry_sel, done;
  logic start, double_wash, dry_wash, time_pause, running, cycle_complete, ack_error;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  wm_control_panel dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_btn      (start_btn),
    .pause_btn      (pause_btn),
    .double_sel     (double_sel),
    .dry_sel        (dry_sel),
    .done           (done),
    .start          (start),
    .double_wash    (double_wash),
    .dry_wash       (dry_wash),
    .time_pause     (time_pause),
    .running        (running),
    .cycle_complete (cycle_complete),
    .ack_error      (ack_error)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".start"},          start,          1'b0);
    check({tag, ".double_wash"},    double_wash,    1'b0);
    check({tag, ".dry_wash"},       dry_wash,       1'b0);
    check({tag, ".time_pause"},     time_pause,     1'b0);
    check({tag, ".running"},        running,        1'b0);
    check({tag, ".cycle_complete"}, cycle_complete, 1'b0);
    check({tag, ".ack_error"},      ack_error,      1'b0);
  endtask

  // Clean pause press: long enough to debounce both edges.
  task automatic pause_click();
    pause_btn = 1'b1;
    repeat (8) step();
    pause_btn = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    rst_n = 1'b0; start_btn = 1'b0; pause_btn = 1'b0;
    double_sel = 1'b0; dry_sel = 1'b0; done = 1'b0;
    @(negedge clk);
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) step();

    // Bouncing start, double wash selected, done held high through the pulse.
    double_sel = 1'b1;
    done       = 1'b1;
    start_btn  = 1'b1; step();
    start_btn  = 1'b0; step();
    start_btn  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("start_pulse[%0d]", i), start, (i == 6));
      if (i == 7) done = 1'b0;
    end
    check("run.running",     running,     1'b1);
    check("run.double_wash", double_wash, 1'b1);
    check("run.dry_wash",    dry_wash,    1'b0);
    check("run.time_pause",  time_pause,  1'b0);
    check("run.ack_error",   ack_error,   1'b0);
    start_btn = 1'b0;
    repeat (8) step();

    // Pause and resume.
    pause_click();
    check("pause1.time_pause", time_pause, 1'b1);
    check("pause1.running",    running,    1'b1);
    pause_click();
    check("pause2.time_pause", time_pause, 1'b0);
    check("pause2.running",    running,    1'b1);

    // Pause press and done in the same cycle: done wins.
    pause_btn = 1'b1;
    repeat (6) step();
    done = 1'b1;
    step();
    check("prio.cycle_complete", cycle_complete, 1'b1);
    check("prio.time_pause",     time_pause,     1'b0);
    check("prio.running",        running,        1'b0);
    done      = 1'b0;
    pause_btn = 1'b0;
    repeat (8) step();
    check("complete_hold.cycle_complete", cycle_complete, 1'b1);
    check("complete_hold.double_wash",    double_wash,    1'b1);

    // Washer never drops done: timeout after 8 WAIT_ACK cycles.
    double_sel = 1'b0;
    done       = 1'b1;
    start_btn  = 1'b1;
    repeat (7) step();
    check("to.start",       start,       1'b1);
    check("to.double_wash", double_wash, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("to.wait_running[%0d]", k), running, 1'b1);
    end
    step();
    check("to.running",   running,   1'b0);
    check("to.ack_error", ack_error, 1'b1);
    check("to.start_low", start,     1'b0);
    done      = 1'b0;
    start_btn = 1'b0;
    repeat (8) step();
    check("to.ack_error_sticky", ack_error, 1'b1);

    // Both selectors set: dry wins; next start clears ack_error.
    double_sel = 1'b1;
    dry_sel    = 1'b1;
    start_btn  = 1'b1;
    repeat (7) step();
    check("both.start",       start,       1'b1);
    check("both.ack_error",   ack_error,   1'b0);
    check("both.dry_wash",    dry_wash,    1'b1);
    check("both.double_wash", double_wash, 1'b0);
    repeat (2) step();
    double_sel = 1'b0;
    dry_sel    = 1'b0;
    repeat (3) step();
    check("sel_toggle.dry_wash",    dry_wash,    1'b1);
    check("sel_toggle.double_wash", double_wash, 1'b0);
    check("sel_toggle.running",     running,     1'b1);
    start_btn = 1'b0;
    repeat (8) step();

    // Reset while paused.
    pause_click();
    check("paused.time_pause", time_pause, 1'b1);
    rst_n = 1'b0;
    step();
    check_all_zero("rst_paused");
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step();
      check($sformatf("post_rst.start[%0d]", j), start, 1'b0);
    end
    check("post_rst.running", running, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/wm_control_panel.md
WM_CONTROL_PANEL -- requirements
Module: wm_control_panel

Interface
REQ-001 SHALL have parameter DEBOUNCE_CNT, default 4: consecutive stable synchronized samples required before a debounced button level changes.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 8: cycles allowed for the washer to drop done after a start pulse.
REQ-003 SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-004 clk  input  1  system clock, shared with Washing_Machine.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start_btn  input  1  raw start push-button, asynchronous, bouncing.
REQ-007 pause_btn  input  1  raw pause push-button, asynchronous, bouncing.
REQ-008 double_sel  input  1  double-wash selector switch level.
REQ-009 dry_sel  input  1  dry-wash selector switch level.
REQ-010 done  input  1  washer done flag, consumed from Washing_Machine.
REQ-011 start  output  1  one-cycle start pulse to Washing_Machine.
REQ-012 double_wash  output  1  latched program option to Washing_Machine.
REQ-013 dry_wash  output  1  latched program option to Washing_Machine.
REQ-014 time_pause  output  1  pause level to Washing_Machine.
REQ-015 running  output  1  high in LAUNCH, WAIT_ACK, RUN and PAUSED.
REQ-016 cycle_complete  output  1  high in COMPLETE.
REQ-017 ack_error  output  1  sticky: washer never acknowledged start.

Function
REQ-018 Each button SHALL pass through a 2-flop synchronizer and then a debouncer; a press event SHALL be a 1-cycle pulse on the debounced rising edge.
REQ-019 The debounced level SHALL change only after DEBOUNCE_CNT consecutive samples that differ from it; any sample equal to it SHALL clear the counter.
REQ-020 The FSM SHALL have states IDLE, LAUNCH, WAIT_ACK, RUN, PAUSED and COMPLETE.
REQ-021 IDLE or COMPLETE + start press -> LAUNCH; at the same edge, double_wash and dry_wash SHALL latch the selector switches.
REQ-022 When dry_sel and double_sel are both 1, dry_wash SHALL latch 1 and double_wash SHALL latch 0.
REQ-023 LAUNCH SHALL last exactly 1 cycle with start=1, then go to WAIT_ACK; start SHALL be 0 in every other state.
REQ-024 WAIT_ACK + done=0 -> RUN; otherwise a counter increments, and when it reaches ACK_TIMEOUT -> IDLE with ack_error=1.
REQ-025 RUN + done=1 -> COMPLETE; RUN + pause press -> PAUSED; done takes priority when both occur in the same cycle.
REQ-026 PAUSED SHALL drive time_pause=1 (0 in all other states); PAUSED + pause press -> RUN; PAUSED + done=1 -> COMPLETE.
REQ-027 Start presses SHALL be ignored in LAUNCH, WAIT_ACK, RUN and PAUSED; pause presses SHALL be ignored in IDLE, LAUNCH, WAIT_ACK and COMPLETE.
REQ-028 Latched options SHALL hold through RUN, PAUSED and COMPLETE, and change only on the next accepted start.
REQ-029 ack_error SHALL clear on the next accepted start press.
REQ-030 Selector changes during a cycle SHALL have no effect on the outputs.

Reset
REQ-031 rst_n=0 at a clk edge SHALL force IDLE, clear all outputs, counters, synchronizers and debounced levels to 0, and clear ack_error.
REQ-032 Reset mid-cycle, including during PAUSED, SHALL drop time_pause and running on that same edge; no start pulse SHALL follow without a new press.

Structure
REQ-033 Package wm_pkg SHALL hold the panel state encoding (3 bits) and the default DEBOUNCE_CNT and ACK_TIMEOUT constants, shared with Washing_Machine's state constants.
REQ-034 Sub-module wm_debounce (synchronizer + counter + edge pulse) SHALL be instantiated once per button.
REQ-035 The FSM, option latches and ack counter SHALL reside in wm_control_panel; total RTL SHALL be 120-400 lines.

Verification
REQ-036 start_btn bouncing 1,0,1 then held high 10 cycles, double_sel=1, done=1 held until after the start pulse, then 0 -> exactly one start pulse, 6 cycles after the first stable sample; double_wash=1; RUN reached.
REQ-037 In RUN, a clean pause_btn press -> time_pause=1; a second press -> time_pause=0; RUN resumes.
REQ-038 In RUN, pause press and done=1 in the same cycle -> COMPLETE, time_pause=0, cycle_complete=1.
REQ-039 After start, done held 1 for 10 cycles -> IDLE after 8 cycles with ack_error=1; next start press clears ack_error.
REQ-040 dry_sel=double_sel=1 at start -> dry_wash=1, double_wash=0; toggle both during RUN -> outputs unchanged.
REQ-041 rst_n=0 for 1 cycle in PAUSED -> next edge: all outputs 0, state IDLE.
